// File: rtl/uart8.sv
// uart8: byte-lane UART peripheral with a TX FIFO feeding an 8N1 shifter, a single RX
// holding register behind a 2-flop synchroniser, a 16-bit divisor and maskable interrupts.
//
// state   | meaning (TX and RX FSMs share the encoding)
// S_IDLE  | line idle; TX waits for FIFO data, RX waits for a falling edge
// S_START | start bit; RX re-checks it at mid-bit to reject glitches
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit; TX chains straight into the next frame if the FIFO has data
module uart8 #(
  parameter logic [15:0] CLK_DIV_RST = 16'd433,
  parameter int          TX_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] addr,
  input  logic       en,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] data_o,
  output logic [7:0] data_i,
  output logic       rdy,
  output logic       txd,
  input  logic       rxd,
  output logic       ext_int
);

  localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(TX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic        r_strobe_q;
  logic        w_strobe, w_access, w_wr, w_rd, w_data_wr, w_data_rd;
  logic [15:0] r_div;
  logic        r_rx_ie, r_tx_ie, r_rx_valid, r_rx_ovr, r_rx_fe;
  logic [7:0]  r_rx_hold;
  logic [7:0]  w_status, w_rd_mux;

  logic [7:0]  r_fifo [TX_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0] r_count;
  logic        w_fifo_full, w_fifo_empty, w_push, w_pop, w_tx_empty;

  state_t      r_tx_state, w_tx_next;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        w_tx_zero;

  state_t      r_rx_state, w_rx_next;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        w_rx_zero, w_rx_fall, w_rx_done, w_rx_ferr;

  // Side effects fire only on the first cycle of a strobe.
  assign w_strobe  = en & (~rd_n | ~wr_n);
  assign w_access  = w_strobe & ~r_strobe_q;
  assign w_wr      = w_access & ~wr_n;
  assign w_rd      = w_access & ~rd_n;
  assign w_data_wr = w_wr & (addr == 2'd0);
  assign w_data_rd = w_rd & (addr == 2'd0);

  assign w_fifo_full  = (r_count == DEPTH_C);
  assign w_fifo_empty = (r_count == '0);
  assign w_push       = w_data_wr & (~w_fifo_full | w_pop);
  assign w_tx_empty   = w_fifo_empty & (r_tx_state == S_IDLE);

  assign w_status = {1'b0, r_rx_fe, r_tx_ie, r_rx_ie, r_rx_ovr, w_tx_empty, w_fifo_full, r_rx_valid};

  always_comb begin
    w_rd_mux = 8'h00;
    case (addr)
      2'd0: w_rd_mux = r_rx_hold;
      2'd1: w_rd_mux = w_status;
      2'd2: w_rd_mux = r_div[7:0];
      2'd3: w_rd_mux = r_div[15:8];
      default: w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_strobe_q <= 1'b0;
      rdy        <= 1'b0;
      data_i     <= 8'h00;
      ext_int    <= 1'b0;
    end else begin
      r_strobe_q <= w_strobe;
      rdy        <= w_strobe;
      if (w_rd) data_i <= w_rd_mux;
      ext_int    <= (r_rx_ie & r_rx_valid) | (r_tx_ie & w_tx_empty);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= CLK_DIV_RST;
      r_rx_ie    <= 1'b0;
      r_tx_ie    <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_rx_fe    <= 1'b0;
      r_rx_hold  <= 8'h00;
    end else begin
      if (w_wr) begin
        case (addr)
          2'd1: begin
            r_rx_ie <= data_o[4];
            r_tx_ie <= data_o[5];
            if (data_o[3]) r_rx_ovr <= 1'b0;
            if (data_o[6]) r_rx_fe  <= 1'b0;
          end
          2'd2: r_div[7:0]  <= data_o;
          2'd3: r_div[15:8] <= data_o;
          default: ;
        endcase
      end
      if (w_data_rd) r_rx_valid <= 1'b0;
      // A new byte beats a same-cycle read; a pending unread byte becomes an overrun.
      if (w_rx_done) begin
        r_rx_hold  <= r_rx_shift;
        r_rx_valid <= 1'b1;
        if (r_rx_valid & ~w_data_rd) r_rx_ovr <= 1'b1;
      end
      if (w_rx_ferr) r_rx_fe <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= data_o;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign w_tx_zero = (r_tx_cnt == 16'd0);

  always_comb begin
    w_tx_next = r_tx_state;
    w_pop     = 1'b0;
    case (r_tx_state)
      S_IDLE:  if (!w_fifo_empty) begin w_tx_next = S_START; w_pop = 1'b1; end
      S_START: if (w_tx_zero) w_tx_next = S_DATA;
      S_DATA:  if (w_tx_zero && r_tx_bit == 3'd7) w_tx_next = S_STOP;
      S_STOP: begin
        if (w_tx_zero) begin
          if (!w_fifo_empty) begin w_tx_next = S_START; w_pop = 1'b1; end
          else w_tx_next = S_IDLE;
        end
      end
      default: w_tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= S_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txd        <= 1'b1;
      r_tx_cnt   <= 16'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'h00;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_shift <= r_fifo[r_rptr];
            r_tx_cnt   <= r_div;
            txd        <= 1'b0;
          end
        end
        S_START: begin
          if (w_tx_zero) begin
            txd        <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_cnt   <= r_div;
            r_tx_bit   <= 3'd0;
          end else r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        S_DATA: begin
          if (w_tx_zero) begin
            r_tx_cnt <= r_div;
            if (r_tx_bit == 3'd7) txd <= 1'b1;
            else begin
              txd        <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_bit   <= r_tx_bit + 3'd1;
            end
          end else r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        S_STOP: begin
          if (w_tx_zero) begin
            if (w_pop) begin
              r_tx_shift <= r_fifo[r_rptr];
              r_tx_cnt   <= r_div;
              txd        <= 1'b0;
            end
          end else r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        default: txd <= 1'b1;
      endcase
    end
  end

  assign w_rx_zero = (r_rx_cnt == 16'd0);
  assign w_rx_fall = r_rx_prev & ~r_rx_s2;
  assign w_rx_done = (r_rx_state == S_STOP) & w_rx_zero & r_rx_s2;
  assign w_rx_ferr = (r_rx_state == S_STOP) & w_rx_zero & ~r_rx_s2;

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      S_IDLE:  if (w_rx_fall) w_rx_next = S_START;
      S_START: if (w_rx_zero) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (w_rx_zero && r_rx_bit == 3'd7) w_rx_next = S_STOP;
      S_STOP:  if (w_rx_zero) w_rx_next = S_IDLE;
      default: w_rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= S_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        S_IDLE: if (w_rx_fall) r_rx_cnt <= r_div >> 1;
        S_START: begin
          if (w_rx_zero) begin
            r_rx_cnt <= r_div;
            r_rx_bit <= 3'd0;
          end else r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        S_DATA: begin
          if (w_rx_zero) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_cnt   <= r_div;
            r_rx_bit   <= r_rx_bit + 3'd1;
          end else r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        S_STOP: if (!w_rx_zero) r_rx_cnt <= r_rx_cnt - 16'd1;
        default: r_rx_cnt <= 16'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart8.sv
// Scoreboarded bench for uart8: bus reads checked by an rdy monitor, serial TX decoded
// against expected bytes, RX flags compared with a frame-level model.
module tb_uart8;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] addr;
  logic       en, rd_n, wr_n;
  logic [7:0] data_o;
  wire  [7:0] data_i;
  wire        rdy, txd, ext_int;
  logic       rxd_drv, loopback;
  wire        rxd_w = loopback ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart8 #(.CLK_DIV_RST(16'd433), .TX_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .en(en), .rd_n(rd_n), .wr_n(wr_n),
    .data_o(data_o), .data_i(data_i), .rdy(rdy), .txd(txd), .rxd(rxd_w), .ext_int(ext_int)
  );

  typedef struct {
    bit         is_rd;
    logic [7:0] exp;
    string      name;
  } acc_t;

  acc_t       sb[$];
  logic [7:0] exp_tx[$];
  int         n_checks = 0;
  int         n_err = 0;
  int         bit_len = 434;
  bit         dec_on = 1'b1;
  bit         mon_rdy_q = 1'b0;
  logic [7:0] dec_b;
  acc_t       mon_e;

  bit         m_valid, m_ovr, m_fe, m_rxie, m_txie;
  logic [7:0] m_hold;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] stat(input bit te, input bit tf);
    return {1'b0, m_fe, m_txie, m_rxie, m_ovr, te, tf, m_valid};
  endfunction

  task automatic bus_acc(input bit is_rd, input logic [1:0] a, input logic [7:0] d,
                         input logic [7:0] exp, input string nm);
    acc_t e;
    e.is_rd = is_rd; e.exp = exp; e.name = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    en = 1'b1; addr = a; data_o = d;
    if (is_rd) rd_n = 1'b0; else wr_n = 1'b0;
    @(posedge clk); #1;
    en = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    bus_acc(1'b0, a, d, 8'h00, "wr");
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [7:0] exp, input string nm);
    bus_acc(1'b1, a, 8'h00, exp, nm);
  endtask

  task automatic set_div(input logic [15:0] dv);
    bus_wr(2'd2, dv[7:0]);
    bus_wr(2'd3, dv[15:8]);
    bit_len = int'(dv) + 1;
  endtask

  task automatic ctrl_wr(input logic [7:0] d);
    bus_wr(2'd1, d);
    m_rxie = d[4];
    m_txie = d[5];
    if (d[3]) m_ovr = 1'b0;
    if (d[6]) m_fe = 1'b0;
  endtask

  function automatic void rx_model(input logic [7:0] b, input bit stop);
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_hold  = b;
    end else m_fe = 1'b1;
  endfunction

  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 rxd_drv = fr[i];
      repeat (bit_len - 1) @(posedge clk);
    end
    @(posedge clk); #1 rxd_drv = 1'b1;
    repeat (2 * bit_len) @(posedge clk);
    rx_model(b, stop);
  endtask

  task automatic wait_tx_done(input int limit);
    for (int i = 0; i < limit && exp_tx.size() > 0; i++) @(posedge clk);
    chk("tx_drain_timeout", exp_tx.size(), 0);
    repeat (bit_len + 4) @(posedge clk);
  endtask

  // Bus monitor: one scoreboard entry per access, compared when rdy rises.
  initial begin
    forever begin
      @(negedge clk);
      if (rdy === 1'b1 && !mon_rdy_q) begin
        if (sb.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL sb_underflow: actual rdy rise required no access");
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.is_rd) chk(mon_e.name, data_i, mon_e.exp);
        end
      end
      mon_rdy_q = (rdy === 1'b1);
    end
  end

  // Serial decoder: mid-bit sampling of txd using the bench's own bit length.
  initial begin
    forever begin
      @(negedge clk);
      if (dec_on && txd === 1'b0) begin
        repeat (bit_len / 2) @(negedge clk);
        chk("tx_start_mid", txd, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (bit_len) @(negedge clk);
          dec_b[i] = txd;
        end
        repeat (bit_len) @(negedge clk);
        chk("tx_stop", txd, 1);
        if (exp_tx.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL tx_unexpected: actual %0h required none", dec_b);
        end else chk("tx_byte", dec_b, exp_tx.pop_front());
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    n_err++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] got, want;
    logic [7:0]  a5, b, rb;
    logic [15:0] dv;
    int          cnt, n, zeros;

    rst = 1'b1; en = 1'b0; rd_n = 1'b1; wr_n = 1'b1; addr = 2'd0; data_o = 8'h00;
    rxd_drv = 1'b1; loopback = 1'b0;
    m_valid = 0; m_ovr = 0; m_fe = 0; m_rxie = 0; m_txie = 0; m_hold = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_txd", txd, 1);
    chk("rst_rdy", rdy, 0);
    chk("rst_ext_int", ext_int, 0);
    bus_rd(2'd1, 8'h04, "rst_status");
    bus_rd(2'd2, 8'hB1, "rst_divl");
    bus_rd(2'd3, 8'h01, "rst_divh");

    // Single 0xA5 frame, captured clock by clock.
    set_div(16'd3);
    a5 = 8'hA5;
    for (int k = 0; k < 40; k++)
      want[k] = (k < 4) ? 1'b0 : (k >= 36) ? 1'b1 : a5[k/4 - 1];
    exp_tx.push_back(a5);
    bus_wr(2'd0, a5);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1 got[k] = txd;
    end
    chk("tx_frame_a5", got, want);
    bus_rd(2'd1, stat(1'b1, 1'b0), "tx_empty_after_frame");

    // Burst of six: shifter + 4 FIFO entries accepted, sixth dropped.
    for (int i = 1; i <= 6; i++) begin
      b = 8'(i);
      if (i <= 5) exp_tx.push_back(b);
      bus_wr(2'd0, b);
    end
    bus_rd(2'd1, stat(1'b0, 1'b1), "fifo_full_status");
    wait_tx_done(600);
    bus_rd(2'd1, stat(1'b1, 1'b0), "fifo_drained_status");

    // Loopback with rx interrupt.
    ctrl_wr(8'h10);
    loopback = 1'b1;
    exp_tx.push_back(8'h3C);
    bus_wr(2'd0, 8'h3C);
    for (int i = 0; i < 300 && ext_int !== 1'b1; i++) @(posedge clk);
    chk("lb_ext_int_rise", ext_int, 1);
    rx_model(8'h3C, 1'b1);
    bus_rd(2'd0, m_hold, "lb_data");
    m_valid = 1'b0;
    @(posedge clk); #1;
    chk("lb_ext_int_fall", ext_int, 0);
    wait_tx_done(200);
    loopback = 1'b0;
    bus_rd(2'd1, stat(1'b1, 1'b0), "lb_status");

    // Overrun, framing error, glitch.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_rd(2'd1, stat(1'b1, 1'b0), "ovr_status");
    bus_rd(2'd0, m_hold, "ovr_data");
    m_valid = 1'b0;
    ctrl_wr(8'h08);
    bus_rd(2'd1, stat(1'b1, 1'b0), "ovr_cleared");
    send_rx(8'h5A, 1'b1);
    send_rx(8'h77, 1'b0);
    bus_rd(2'd1, stat(1'b1, 1'b0), "fe_status");
    bus_rd(2'd0, m_hold, "fe_data_kept");
    m_valid = 1'b0;
    ctrl_wr(8'h40);
    bus_rd(2'd1, stat(1'b1, 1'b0), "fe_cleared");
    @(posedge clk); #1 rxd_drv = 1'b0;
    @(posedge clk); #1 rxd_drv = 1'b1;
    repeat (10 * bit_len) @(posedge clk);
    bus_rd(2'd1, stat(1'b1, 1'b0), "glitch_status");

    // Write strobe held for five cycles.
    begin
      acc_t e;
      e.is_rd = 1'b0; e.exp = 8'h00; e.name = "held_wr";
      sb.push_back(e);
    end
    exp_tx.push_back(8'h5E);
    cnt = 0;
    @(posedge clk); #1;
    en = 1'b1; addr = 2'd0; data_o = 8'h5E; wr_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rdy === 1'b1) cnt++;
      @(posedge clk);
    end
    #1 en = 1'b0; wr_n = 1'b1;
    chk("held_rdy_cycles", cnt, 4);
    bus_rd(2'd1, stat(1'b0, 1'b0), "held_status");
    wait_tx_done(200);
    repeat (12 * bit_len) @(posedge clk);
    bus_rd(2'd1, stat(1'b1, 1'b0), "held_drained");

    // Randomised divisor, control bits, TX bursts and RX bytes.
    for (int it = 0; it < 6; it++) begin
      dv = 16'($urandom_range(3, 9));
      set_div(dv);
      bus_rd(2'd2, dv[7:0], "rnd_divl");
      ctrl_wr(8'($urandom) & 8'h78);
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        if (j < 5) exp_tx.push_back(b);
        bus_wr(2'd0, b);
      end
      bus_rd(2'd1, stat(1'b0, n >= 5), "rnd_burst_status");
      rb = 8'($urandom);
      send_rx(rb, 1'b1);
      bus_rd(2'd0, m_hold, "rnd_rx_data");
      m_valid = 1'b0;
      wait_tx_done(60 * bit_len + 100);
      bus_rd(2'd1, stat(1'b1, 1'b0), "rnd_idle_status");
      repeat (2) @(posedge clk); #1;
      chk("rnd_ext_int", ext_int, (m_rxie & m_valid) | m_txie);
    end

    // Reset during the fourth data bit of 0x96 with more bytes queued.
    set_div(16'd3);
    dec_on = 1'b0;
    bus_wr(2'd0, 8'h96);
    bus_wr(2'd0, 8'h33);
    bus_wr(2'd0, 8'h44);
    repeat (13) @(posedge clk);
    #1 chk("pre_rst_txd_bit3", txd, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_txd", txd, 1);
    rst = 1'b0;
    m_valid = 0; m_ovr = 0; m_fe = 0; m_rxie = 0; m_txie = 0;
    bus_rd(2'd1, stat(1'b1, 1'b0), "rst_mid_status");
    zeros = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (txd !== 1'b1) zeros++;
    end
    chk("rst_mid_txd_idle", zeros, 0);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    chk("sb_drain", sb.size(), 0);
    chk("tx_exp_drain", exp_tx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
